// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the symbol-matching game.
// Holds the FSM state enum and the LFSR width, seed and tap mask.
package game_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        RESULT
    } state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: free-running 16-bit Fibonacci LFSR, seeded on reset.
// Ports: clk_i, s_rst_n_i (sync, active-low), lfsr_o (current state).
module game_lfsr
    import game_pkg::*;
(
    input  logic              clk_i,
    input  logic              s_rst_n_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            lfsr_o <= LFSR_SEED;
        end else begin
            lfsr_o <= {lfsr_o[LFSR_W-2:0], lfsr_fb(lfsr_o)};
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: round sequencer - draws symbols, times rounds, judges guesses,
// tracks score/lives and reports the outcome.
// Ports: clk_i, s_rst_n_i (sync, active-low), start_i, guess_i,
//   guess_valid_i in; current_symbol_o, user_in_game_o,
//   user_win_nlost_o, score_o out (all registered).
// Option: GAME_CTRL_SPEEDUP_EN shrinks the round limit by 1/8 per hit,
//   floored at MIN_ROUND_TICKS.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SYMBOL_W        = 8,
    parameter int ROUND_TICKS     = 25000000,
    parameter int MIN_ROUND_TICKS = 6250000,
    parameter int RESULT_TICKS    = 50000000,
    parameter int WIN_SCORE       = 8,
    parameter int LIVES           = 3
) (
    input  logic                         clk_i,
    input  logic                         s_rst_n_i,
    input  logic                         start_i,
    input  logic [SYMBOL_W-1:0]          guess_i,
    input  logic                         guess_valid_i,
    output logic [SYMBOL_W-1:0]          current_symbol_o,
    output logic                         user_in_game_o,
    output logic                         user_win_nlost_o,
    output logic [$clog2(WIN_SCORE+1)-1:0] score_o
);

    localparam int LIM_MAX = (MIN_ROUND_TICKS > ROUND_TICKS)
                           ? MIN_ROUND_TICKS : ROUND_TICKS;
    localparam int SCORE_W = $clog2(WIN_SCORE + 1);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int RND_W   = $clog2(LIM_MAX + 1);
    localparam int RES_W   = $clog2(RESULT_TICKS + 1);

    state_e              state;
    logic [LFSR_W-1:0]   lfsr;
    logic [LIVES_W-1:0]  lives;
    logic [RND_W-1:0]    round_limit;
    logic [RND_W-1:0]    rnd_cnt;
    logic [RES_W-1:0]    res_cnt;

    logic [SYMBOL_W-1:0] new_sym;
    logic [SCORE_W-1:0]  score_inc;
    logic [LIVES_W-1:0]  lives_dec;
    logic [RND_W-1:0]    lim_next;
    logic                timeout;
    logic                hit;
    logic                miss;
    logic                unused_lfsr;

    game_lfsr u_lfsr (
        .clk_i     (clk_i),
        .s_rst_n_i (s_rst_n_i),
        .lfsr_o    (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    // Zero is reserved for "no symbol", so a zero draw becomes 1.
    assign new_sym = (lfsr[SYMBOL_W-1:0] == '0)
                   ? SYMBOL_W'(1) : lfsr[SYMBOL_W-1:0];

    assign score_inc = score_o + SCORE_W'(1);
    assign lives_dec = lives - LIVES_W'(1);
    assign timeout   = (rnd_cnt == round_limit - RND_W'(1));
    // A guess arriving on the timeout cycle takes precedence.
    assign hit  = guess_valid_i && (guess_i == current_symbol_o);
    assign miss = (guess_valid_i && !hit) || (!guess_valid_i && timeout);

`ifdef GAME_CTRL_SPEEDUP_EN
    logic [RND_W-1:0] lim_dec;
    assign lim_dec  = round_limit - (round_limit >> 3);
    assign lim_next = (lim_dec < RND_W'(MIN_ROUND_TICKS))
                    ? RND_W'(MIN_ROUND_TICKS) : lim_dec;
`else
    assign lim_next = round_limit;
`endif

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state            <= IDLE;
            current_symbol_o <= '0;
            user_in_game_o   <= 1'b0;
            user_win_nlost_o <= 1'b0;
            score_o          <= '0;
            lives            <= '0;
            round_limit      <= RND_W'(ROUND_TICKS);
            rnd_cnt          <= '0;
            res_cnt          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state            <= LOAD;
                        score_o          <= '0;
                        lives            <= LIVES_W'(LIVES);
                        round_limit      <= RND_W'(ROUND_TICKS);
                        user_win_nlost_o <= 1'b0;
                        user_in_game_o   <= 1'b1;
                    end
                end
                LOAD: begin
                    current_symbol_o <= new_sym;
                    rnd_cnt          <= '0;
                    state            <= PLAY;
                end
                PLAY: begin
                    rnd_cnt <= rnd_cnt + RND_W'(1);
                    unique case (1'b1)
                        hit: begin
                            score_o     <= score_inc;
                            round_limit <= lim_next;
                            if (score_inc == SCORE_W'(WIN_SCORE)) begin
                                state            <= RESULT;
                                user_win_nlost_o <= 1'b1;
                                user_in_game_o   <= 1'b0;
                                current_symbol_o <= '0;
                                res_cnt          <= '0;
                            end else begin
                                state <= LOAD;
                            end
                        end
                        miss: begin
                            lives <= lives_dec;
                            if (lives_dec == '0) begin
                                state            <= RESULT;
                                user_win_nlost_o <= 1'b0;
                                user_in_game_o   <= 1'b0;
                                current_symbol_o <= '0;
                                res_cnt          <= '0;
                            end else begin
                                state <= LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
                RESULT: begin
                    if (res_cnt == RES_W'(RESULT_TICKS - 1)) begin
                        state <= IDLE;
                    end else begin
                        res_cnt <= res_cnt + RES_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
